axis_packet_sequencer: RTL

AXIS_PACKET_SEQUENCER -- requirements
Module: axis_packet_sequencer

---
 rtl/axis_packet_sequencer.sv | 79 +++++++
 1 files changed

// File: rtl/axis_packet_sequencer.sv
// Splits an AXI-Stream beat sequence into fixed-size datapoints of PACKETS_NUM beats.
// Each accepted beat is re-issued one cycle later with a one-hot packet strobe.
module axis_packet_sequencer #(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned PACKETS_NUM            = 13,
    parameter int unsigned CNT_W                  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    input  logic                              finish,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0] x,
    output logic [PACKETS_NUM-1:0]            valid,
    output logic [CNT_W-1:0]                  packet_counter,
    output logic                              last,
    output logic [31:0]                       dp_count,
    output logic                              proto_err
);

    typedef enum logic [0:0] {StRecv, StWait} state_e;

    localparam logic [CNT_W-1:0]       LastIdx = CNT_W'(PACKETS_NUM - 1);
    localparam logic [PACKETS_NUM-1:0] OneHot0 = PACKETS_NUM'(1);

    state_e           state_q;
    logic [CNT_W-1:0] pkt_idx_q;
    logic             accept;

    // Gating with rst keeps tready low during reset even though state only clears at the edge.
    assign s_axis_tready = (state_q == StRecv) && !rst;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRecv;
            pkt_idx_q      <= '0;
            x              <= '0;
            valid          <= '0;
            packet_counter <= '0;
            last           <= 1'b0;
            dp_count       <= '0;
            proto_err      <= 1'b0;
        end else begin
            valid <= '0;
            last  <= 1'b0;
            unique case (state_q)
                StRecv: begin
                    if (accept) begin
                        x              <= s_axis_tdata;
                        packet_counter <= pkt_idx_q;
                        valid          <= OneHot0 << pkt_idx_q;
                        if (pkt_idx_q == LastIdx) begin
                            pkt_idx_q <= '0;
                            dp_count  <= dp_count + 32'd1;
                            last      <= s_axis_tlast;
                            state_q   <= StWait;
                        end else if (s_axis_tlast) begin
                            // Early tlast: drop the partial datapoint and resync to packet 0.
                            pkt_idx_q <= '0;
                            proto_err <= 1'b1;
                        end else begin
                            pkt_idx_q <= pkt_idx_q + CNT_W'(1);
                        end
                    end
                end
                StWait: begin
                    if (finish) begin
                        state_q <= StRecv;
                    end
                end
                default: state_q <= StRecv;
            endcase
        end
    end

endmodule
